// File: rtl/alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// alu_share_ctrl
//
// Lets two requesters share one 4-bit ALU:
//   requester 0 : board buttons / switches
//   requester 1 : self-test script
//
// One operation is in flight at a time. An operation goes through three phases:
//   IDLE - arbitrate and accept one request, registering its operands
//   WAIT - let the ALU settle for ALU_LAT cycles, then capture its result
//   RESP - hold the result until the consumer takes it
// After the result is consumed, the controller returns to IDLE.
//
// Configuration macro:
//   ALU_SHARE_FIXED_PRIO_EN
//     defined   : requester 0 always wins when both requesters are valid.
//     undefined : round-robin between the requesters (default build).
//
// Parameters:
//   DATA_W  - operand width (A, B)
//   OP_W    - opcode width
//   Y_W     - ALU BCD result width
//   ALU_LAT - ALU settle cycles between operand issue and result capture (>=1)
//
// Ports:
//   clk, rst                    clock; asynchronous active-high reset
//   reqN_valid / reqN_ready     request handshake for requester N (N = 0, 1);
//                               reqN_ready is combinational and only in IDLE
//   reqN_a, reqN_b, reqN_op     operands and opcode, sampled only at accept
//   alu_a, alu_b, alu_op        registered operands to the ALU; these keep
//                               their values after completion so the display
//                               stays stable
//   alu_cin                     ALU carry-in, tied to 0
//   alu_y, alu_cout, alu_ovf    ALU result and flags
//   rsp_valid / rsp_ready       response handshake; rsp_valid is held until
//                               the consumer accepts the response
//   rsp_id                      requester that owns the response
//   rsp_y                       captured ALU result
//   rsp_flags                   captured flags, {overflow, carry-out}
//   busy                        high whenever the controller is not in IDLE
// -----------------------------------------------------------------------------
module alu_share_ctrl #(
  parameter int DATA_W  = 4,
  parameter int OP_W    = 3,
  parameter int Y_W     = 12,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,

  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_cin,
  input  logic [Y_W-1:0]    alu_y,
  input  logic              alu_cout,
  input  logic              alu_ovf,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [Y_W-1:0]    rsp_y,
  output logic [1:0]        rsp_flags,

  output logic              busy
);

  // The settle counter only has to reach ALU_LAT-1.
  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;

  logic              any_req;
  logic              gnt_id;
  logic [DATA_W-1:0] gnt_a_p0;
  logic [DATA_W-1:0] gnt_b_p0;
  logic [OP_W-1:0]   gnt_op_p0;

`ifndef ALU_SHARE_FIXED_PRIO_EN
  // Requester granted most recently. It resets to 1 so that requester 0
  // wins the first tie.
  logic              last_id;
`endif

  assign alu_cin = 1'b0;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req)         state_nxt = WAIT;
      WAIT:    if (cnt == CNT_LAST) state_nxt = RESP;
      RESP:    if (rsp_ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic. Stage p0: arbitration and operand select.
  // ---------------------------------------------------------------------------
  always_comb begin
    any_req = req0_valid | req1_valid;

    // When only one requester is valid, that requester is granted.
    gnt_id  = req1_valid & ~req0_valid;
    if (req0_valid && req1_valid) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
      gnt_id = 1'b0;
`else
      gnt_id = ~last_id;
`endif
    end

    gnt_a_p0  = gnt_id ? req1_a  : req0_a;
    gnt_b_p0  = gnt_id ? req1_b  : req0_b;
    gnt_op_p0 = gnt_id ? req1_op : req0_op;

    // The ready outputs are masked while reset is asserted, so every output
    // is 0 for the whole reset window, even if a requester is holding valid.
    req0_ready = (state == IDLE) & any_req & ~gnt_id & ~rst;
    req1_ready = (state == IDLE) & any_req &  gnt_id & ~rst;
    busy       = (state != IDLE);
  end

  // ---------------------------------------------------------------------------
  // Stage p1: issue registers to the ALU, settle counter and response capture.
  // These registers drive outputs that must read 0 in reset, so they take the
  // asynchronous reset as well.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_y     <= '0;
      rsp_flags <= 2'b00;
`ifndef ALU_SHARE_FIXED_PRIO_EN
      last_id   <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            alu_a   <= gnt_a_p0;
            alu_b   <= gnt_b_p0;
            alu_op  <= gnt_op_p0;
            rsp_id  <= gnt_id;
            cnt     <= '0;
`ifndef ALU_SHARE_FIXED_PRIO_EN
            last_id <= gnt_id;
`endif
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          // The counter wraps back to 0 when ALU_LAT is a power of two. That
          // is harmless, because cnt is reloaded at the next accept.
          if (cnt == CNT_LAST) begin
            rsp_y     <= alu_y;
            rsp_flags <= {alu_ovf, alu_cout};
            rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
